// File: rtl/axilite_master.sv
// axilite_master: single-outstanding AXI-Lite initiator.
// Each local command becomes one AW/W write or one AR/R read. The target
// slave has no B channel, so a write is complete once both the AW and W
// handshakes have happened. A read is complete when rvalid is seen in or
// after the AR handshake cycle. A cycle counter aborts a stalled transfer
// and returns an error response. All AXI outputs are decoded from
// registered state and flags only, so no AXI input reaches an AXI output
// combinationally.
module axilite_master #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int pTIMEOUT    = 256,
    parameter int pCNT_WIDTH  = 9
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst,

    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_write,
    input  logic [pADDR_WIDTH-1:0] cmd_addr,
    input  logic [pDATA_WIDTH-1:0] cmd_wdata,

    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [pDATA_WIDTH-1:0] rsp_rdata,
    output logic                   rsp_err,

    output logic                   busy,

    output logic                   awvalid,
    input  logic                   awready,
    output logic [pADDR_WIDTH-1:0] awaddr,

    output logic                   wvalid,
    input  logic                   wready,
    output logic [pDATA_WIDTH-1:0] wdata,

    output logic                   arvalid,
    input  logic                   arready,
    output logic [pADDR_WIDTH-1:0] araddr,

    output logic                   rready,
    input  logic                   rvalid,
    input  logic [pDATA_WIDTH-1:0] rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WR   = 2'd1;
    localparam logic [1:0] S_RD   = 2'd2;
    localparam logic [1:0] S_RSP  = 2'd3;

    localparam logic [pCNT_WIDTH-1:0] CNT_LAST = pCNT_WIDTH'(pTIMEOUT - 1);
    localparam logic [pCNT_WIDTH-1:0] CNT_ONE  = pCNT_WIDTH'(1);

    logic [1:0]             state;
    logic [pADDR_WIDTH-1:0] addr_q;
    logic [pDATA_WIDTH-1:0] wdata_q;
    logic [pDATA_WIDTH-1:0] rsp_rdata_q;
    logic                   rsp_err_q;
    logic [pCNT_WIDTH-1:0]  cnt;
    logic                   aw_done;
    logic                   w_done;
    logic                   ar_done;

    logic                   in_wr;
    logic                   in_rd;
    logic                   aw_fire;
    logic                   w_fire;
    logic                   ar_fire;
    logic                   wr_complete;
    logic                   rd_accept;
    logic                   timeout_hit;

    // Output decode from registered state and handshake flags only.
    always_comb begin
        in_wr     = (state == S_WR);
        in_rd     = (state == S_RD);

        cmd_ready = (state == S_IDLE);
        busy      = (state != S_IDLE);
        rsp_valid = (state == S_RSP);
        rsp_rdata = rsp_valid ? rsp_rdata_q : '0;
        rsp_err   = rsp_valid & rsp_err_q;

        awvalid   = in_wr & ~aw_done;
        wvalid    = in_wr & ~w_done;
        awaddr    = in_wr ? addr_q  : '0;
        wdata     = in_wr ? wdata_q : '0;

        arvalid   = in_rd & ~ar_done;
        araddr    = in_rd ? addr_q : '0;
        // Held for the whole read because the slave gates arready on rready.
        rready    = in_rd;
    end

    // Handshake and completion qualifiers for the current cycle.
    always_comb begin
        aw_fire     = awvalid & awready;
        w_fire      = wvalid & wready;
        ar_fire     = arvalid & arready;
        // Each half may finish in an earlier cycle or in this one.
        wr_complete = (aw_done | aw_fire) & (w_done | w_fire);
        // rvalid counts only once the AR handshake is done or happening now.
        rd_accept   = (ar_done | ar_fire) & rvalid;
        timeout_hit = (cnt == CNT_LAST);
    end

    // Transaction state machine, latched command and response registers.
    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            state       <= S_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            cnt         <= '0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            ar_done     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        addr_q      <= cmd_addr;
                        wdata_q     <= cmd_wdata;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b0;
                        cnt         <= '0;
                        aw_done     <= 1'b0;
                        w_done      <= 1'b0;
                        ar_done     <= 1'b0;
                        state       <= cmd_write ? S_WR : S_RD;
                    end
                end

                S_WR: begin
                    cnt <= cnt + CNT_ONE;
                    if (aw_fire) begin
                        aw_done <= 1'b1;
                    end
                    if (w_fire) begin
                        w_done <= 1'b1;
                    end
                    // Completion is tested first so it wins over a same-cycle timeout.
                    if (wr_complete) begin
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b0;
                        state       <= S_RSP;
                    end else if (timeout_hit) begin
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b1;
                        state       <= S_RSP;
                    end
                end

                S_RD: begin
                    cnt <= cnt + CNT_ONE;
                    if (ar_fire) begin
                        ar_done <= 1'b1;
                    end
                    if (rd_accept) begin
                        rsp_rdata_q <= rdata;
                        rsp_err_q   <= 1'b0;
                        state       <= S_RSP;
                    end else if (timeout_hit) begin
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b1;
                        state       <= S_RSP;
                    end
                end

                S_RSP: begin
                    if (rsp_ready) begin
                        state <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axilite_master.sv
// Bench for axilite_master: table of transactions with per-cycle slave
// behaviour, expected responses queued when the command is issued and
// compared when the response handshake happens, plus hand-written
// sequences for reset after power-up and reset in the middle of a write.
module tb_axilite_master;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int TO = 8;
    localparam int MAX_CYC = 20;

    logic          axis_clk = 1'b0;
    logic          axis_rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          busy;
    logic          awvalid;
    logic          awready;
    logic [AW-1:0] awaddr;
    logic          wvalid;
    logic          wready;
    logic [DW-1:0] wdata;
    logic          arvalid;
    logic          arready;
    logic [AW-1:0] araddr;
    logic          rready;
    logic          rvalid;
    logic [DW-1:0] rdata;

    always #5 axis_clk = ~axis_clk;

    axilite_master #(
        .pADDR_WIDTH(AW),
        .pDATA_WIDTH(DW),
        .pTIMEOUT   (TO),
        .pCNT_WIDTH (4)
    ) dut (
        .axis_clk (axis_clk),
        .axis_rst (axis_rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr (cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .busy     (busy),
        .awvalid  (awvalid),
        .awready  (awready),
        .awaddr   (awaddr),
        .wvalid   (wvalid),
        .wready   (wready),
        .wdata    (wdata),
        .arvalid  (arvalid),
        .arready  (arready),
        .araddr   (araddr),
        .rready   (rready),
        .rvalid   (rvalid),
        .rdata    (rdata)
    );

    // One transaction: command, slave timing (cycle numbers counted from
    // the first bus cycle after the command handshake; 0 = never) and
    // expected results.
    typedef struct {
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            aw_at;
        int            w_at;
        int            ar_at;
        int            r_at;
        int            r_early;
        logic [DW-1:0] rdata;
        logic          exp_err;
        logic [DW-1:0] exp_rdata;
        int            exp_rsp;
        int            exp_aw;
        int            exp_w;
        int            exp_ar;
        int            stall;
    } vec_t;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;

    vec_t vecs[13];
    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge axis_clk);
        #1;
    endtask

    function automatic vec_t mk(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                                input int aw_at, input int w_at, input int ar_at, input int r_at,
                                input int r_early, input logic [DW-1:0] rd, input logic e_err,
                                input logic [DW-1:0] e_rd, input int e_rsp, input int e_aw,
                                input int e_w, input int e_ar, input int stall);
        vec_t v;
        v.write = w;       v.addr = a;         v.wdata = d;
        v.aw_at = aw_at;   v.w_at = w_at;      v.ar_at = ar_at;
        v.r_at = r_at;     v.r_early = r_early; v.rdata = rd;
        v.exp_err = e_err; v.exp_rdata = e_rd; v.exp_rsp = e_rsp;
        v.exp_aw = e_aw;   v.exp_w = e_w;      v.exp_ar = e_ar;
        v.stall = stall;
        return v;
    endfunction

    task automatic check_idle_outputs(input string tag);
        chk({tag, ".cmd_ready"}, 64'(cmd_ready), 64'd1);
        chk({tag, ".busy"},      64'(busy),      64'd0);
        chk({tag, ".rsp_valid"}, 64'(rsp_valid), 64'd0);
        chk({tag, ".rsp_rdata"}, 64'(rsp_rdata), 64'd0);
        chk({tag, ".rsp_err"},   64'(rsp_err),   64'd0);
        chk({tag, ".axi_valids"}, 64'({awvalid, wvalid, arvalid, rready}), 64'd0);
        chk({tag, ".axi_addr_data"}, 64'({awaddr, araddr, wdata}), 64'd0);
    endtask

    task automatic run_txn(input vec_t v, input int idx);
        string tag;
        int    aw_n;
        int    w_n;
        int    ar_n;
        int    rr_n;
        int    rsp_cyc;
        bit    addr_ok;
        bit    data_ok;
        bit    cmdr_ok;
        bit    stable_ok;
        logic [DW:0] held;
        exp_t  e;

        tag = $sformatf("v%0d", idx);
        aw_n = 0; w_n = 0; ar_n = 0; rr_n = 0; rsp_cyc = -1;
        addr_ok = 1'b1; data_ok = 1'b1; cmdr_ok = 1'b1; stable_ok = 1'b1;

        // Cycle 0: command handshake.
        chk({tag, ".cmd_ready"}, 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1;
        cmd_write = v.write;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        sb.push_back('{rdata: v.exp_rdata, err: v.exp_err});
        step();
        // Scramble the command inputs to show the DUT uses its latched copy.
        cmd_valid = 1'b0;
        cmd_addr  = ~v.addr;
        cmd_wdata = ~v.wdata;

        for (int c = 1; c <= MAX_CYC; c++) begin
            if (rsp_valid) begin
                rsp_cyc = c;
                break;
            end
            awready = (v.aw_at == c);
            wready  = (v.w_at == c);
            arready = (v.ar_at == c) && rready;
            rvalid  = (v.r_at == c) || (v.r_early == c);
            rdata   = (v.r_at == c) ? v.rdata : 32'hDEAD_BEEF;
            if (awvalid) begin
                aw_n++;
                if (awaddr !== v.addr) addr_ok = 1'b0;
            end
            if (wvalid) begin
                w_n++;
                if (wdata !== v.wdata) data_ok = 1'b0;
            end
            if (arvalid) begin
                ar_n++;
                if (araddr !== v.addr) addr_ok = 1'b0;
            end
            if (rready) rr_n++;
            if (cmd_ready || !busy) cmdr_ok = 1'b0;
            step();
        end
        awready = 1'b0; wready = 1'b0; arready = 1'b0; rvalid = 1'b0; rdata = '0;

        chk({tag, ".rsp_cycle"}, 64'(rsp_cyc), 64'(v.exp_rsp));
        chk({tag, ".aw_cycles"}, 64'(aw_n), 64'(v.exp_aw));
        chk({tag, ".w_cycles"},  64'(w_n),  64'(v.exp_w));
        chk({tag, ".ar_cycles"}, 64'(ar_n), 64'(v.exp_ar));
        chk({tag, ".rready_cycles"}, 64'(rr_n), v.write ? 64'd0 : 64'(v.exp_rsp - 1));
        chk({tag, ".addr_data_stable"}, 64'({addr_ok, data_ok}), 64'b11);
        chk({tag, ".busy_no_cmd_ready"}, 64'(cmdr_ok), 64'd1);

        if (rsp_cyc < 0) begin
            void'(sb.pop_front());
            return;
        end

        chk({tag, ".rsp_axi_quiet"}, 64'({awvalid, wvalid, arvalid, rready}), 64'd0);

        if (v.stall > 0) begin
            held = {rsp_err, rsp_rdata};
            for (int s = 0; s < v.stall; s++) begin
                step();
                if (!rsp_valid || {rsp_err, rsp_rdata} !== held) stable_ok = 1'b0;
            end
            chk({tag, ".rsp_stable"}, 64'(stable_ok), 64'd1);
        end

        rsp_ready = 1'b1;
        e = sb.pop_front();
        chk({tag, ".rsp_rdata"}, 64'(rsp_rdata), 64'(e.rdata));
        chk({tag, ".rsp_err"},   64'(rsp_err),   64'(e.err));
        step();
        rsp_ready = 1'b0;
        chk({tag, ".back_idle"}, 64'({cmd_ready, busy, rsp_valid}), 64'b100);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit quiet_ok;

        // write, addr, wdata, aw, w, ar, r, r_early, rdata,
        // exp_err, exp_rdata, exp_rsp, exp_aw, exp_w, exp_ar, stall
        vecs[0]  = mk(1'b1, 12'h020, 32'h0000_0005, 1, 1, 0, 0, 0, '0, 1'b0, '0, 2, 1, 1, 0, 0);
        vecs[1]  = mk(1'b1, 12'h024, 32'hA5A5_0001, 1, 3, 0, 0, 0, '0, 1'b0, '0, 4, 1, 3, 0, 0);
        vecs[2]  = mk(1'b1, 12'h028, 32'h1111_2222, 3, 2, 0, 0, 0, '0, 1'b0, '0, 4, 3, 2, 0, 0);
        vecs[3]  = mk(1'b0, 12'h000, '0, 0, 0, 1, 1, 0, 32'h4, 1'b0, 32'h0000_0004, 2, 0, 0, 1, 0);
        vecs[4]  = mk(1'b0, 12'h010, '0, 0, 0, 1, 5, 0, 32'h40, 1'b0, 32'h40, 6, 0, 0, 1, 0);
        vecs[5]  = mk(1'b0, 12'h014, '0, 0, 0, 3, 3, 1, 32'h77, 1'b0, 32'h77, 4, 0, 0, 3, 0);
        vecs[6]  = mk(1'b1, 12'h030, 32'hDEAD_0006, 0, 1, 0, 0, 0, '0, 1'b1, '0, 9, 8, 1, 0, 0);
        vecs[7]  = mk(1'b1, 12'h020, 32'h0000_0006, 1, 1, 0, 0, 0, '0, 1'b0, '0, 2, 1, 1, 0, 0);
        vecs[8]  = mk(1'b0, 12'h034, '0, 0, 0, 0, 0, 0, '0, 1'b1, '0, 9, 0, 0, 8, 0);
        vecs[9]  = mk(1'b0, 12'h038, '0, 0, 0, 2, 0, 0, '0, 1'b1, '0, 9, 0, 0, 2, 0);
        vecs[10] = mk(1'b1, 12'h03C, 32'h1234_5678, 8, 8, 0, 0, 0, '0, 1'b0, '0, 9, 8, 8, 0, 0);
        vecs[11] = mk(1'b0, 12'h040, '0, 0, 0, 8, 8, 0, 32'h1234, 1'b0, 32'h1234, 9, 0, 0, 8, 0);
        vecs[12] = mk(1'b0, 12'h008, '0, 0, 0, 1, 2, 0, 32'hCAFE_0001, 1'b0, 32'hCAFE_0001, 3, 0, 0, 1, 4);

        axis_rst  = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0;
        awready = 1'b0; wready = 1'b0; arready = 1'b0; rvalid = 1'b0; rdata = '0;
        repeat (3) step();
        axis_rst = 1'b0;
        check_idle_outputs("reset");

        for (int i = 0; i < 13; i++) begin
            run_txn(vecs[i], i);
        end

        // Reset in the third WR cycle of a write the slave never accepts.
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h044; cmd_wdata = 32'h0BAD_F00D;
        step();
        cmd_valid = 1'b0;
        step();
        step();
        chk("midrst.in_wr", 64'({awvalid, wvalid, busy}), 64'b111);
        axis_rst = 1'b1;
        step();
        axis_rst = 1'b0;
        check_idle_outputs("midrst");
        quiet_ok = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (rsp_valid || busy) quiet_ok = 1'b0;
            step();
        end
        chk("midrst.no_response", 64'(quiet_ok), 64'd1);

        run_txn(vecs[3], 13);
        run_txn(vecs[1], 14);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
